// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: golden run, then one MISR-compressed run per fault ID,
// streaming one detect/signature record per fault over valid/ready.
module fault_campaign_ctrl #(
    parameter int unsigned IN_W    = 24,
    parameter int unsigned OUT_W   = 25,
    parameter int unsigned FID_W   = 16,
    parameter int unsigned STEPS   = 128,
    parameter int unsigned PER_HI  = 2,
    parameter int unsigned PER_MID = 32,
    parameter int unsigned PER_LO  = 64,
    parameter int unsigned SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [FID_W-1:0] fid_start_i,
    input  logic [FID_W-1:0] fid_end_i,
    output logic [FID_W-1:0] fault_id_o,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [FID_W-1:0] res_fid_o,
    output logic             res_det_o,
    output logic [OUT_W-1:0] res_sig_o,
    output logic [OUT_W-1:0] golden_sig_o,
    output logic [FID_W-1:0] det_cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned GW = IN_W / 3;
    localparam int unsigned SW = $clog2(STEPS + 1);
    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [FID_W-1:0] NO_FAULT = '1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_EMIT, S_DONE} state_t;

    state_t           state;
    logic [FID_W-1:0] fid_start_q;
    logic [FID_W-1:0] fid_end_q;
    logic             golden_q;
    logic [SW-1:0]    step_q;
    logic [CW-1:0]    sub_q;
    logic [OUT_W-1:0] sig_q;

    logic [OUT_W-1:0] sig_next_c;
    logic [SW-1:0]    step_inc_c;
    logic [SW-1:0]    gray_c;
    logic [IN_W-1:0]  stim_next_c;
    logic [FID_W-1:0] fid_next_c;
    logic             last_sub_c;
    logic             last_step_c;

    // MISR update, next-step stimulus (groups reload only on multiples of their period)
    always_comb begin
        sig_next_c  = {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ dut_out_i;
        step_inc_c  = step_q + SW'(1);
        gray_c      = step_inc_c ^ (step_inc_c >> 1);
        stim_next_c = stim_o;
        if ((32'(step_inc_c) % PER_HI) == 32'd0)
            stim_next_c[GW-1:0] = GW'(gray_c);
        if ((32'(step_inc_c) % PER_MID) == 32'd0)
            stim_next_c[2*GW-1:GW] = GW'(gray_c);
        if ((32'(step_inc_c) % PER_LO) == 32'd0)
            stim_next_c[3*GW-1:2*GW] = GW'(gray_c);
        fid_next_c  = golden_q ? fid_start_q : fault_id_o + FID_W'(1);
        last_sub_c  = (sub_q == CW'(SETTLE));
        last_step_c = (step_q == SW'(STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort_i) begin
            state        <= S_IDLE;
            fault_id_o   <= NO_FAULT;
            stim_o       <= '0;
            res_valid_o  <= 1'b0;
            res_fid_o    <= '0;
            res_det_o    <= 1'b0;
            res_sig_o    <= '0;
            golden_sig_o <= '0;
            det_cnt_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fid_start_q  <= '0;
            fid_end_q    <= '0;
            golden_q     <= 1'b0;
            step_q       <= '0;
            sub_q        <= '0;
            sig_q        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        fid_start_q <= fid_start_i;
                        fid_end_q   <= fid_end_i;
                        fault_id_o  <= NO_FAULT;
                        det_cnt_o   <= '0;
                        golden_q    <= 1'b1;
                        stim_o      <= '0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    step_q <= '0;
                    sub_q  <= '0;
                    sig_q  <= '0;
                    stim_o <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (last_sub_c) begin
                        sig_q <= sig_next_c;
                        sub_q <= '0;
                        if (last_step_c) begin
                            state <= S_EMIT;
                            if (golden_q) begin
                                golden_sig_o <= sig_next_c;
                            end else begin
                                res_valid_o <= 1'b1;
                                res_fid_o   <= fault_id_o;
                                res_det_o   <= (sig_next_c != golden_sig_o);
                                res_sig_o   <= sig_next_c;
                            end
                        end else begin
                            step_q <= step_inc_c;
                            stim_o <= stim_next_c;
                        end
                    end else begin
                        sub_q <= sub_q + CW'(1);
                    end
                end
                S_EMIT: begin
                    // golden EMIT is a single cycle; fault EMIT waits for the handshake
                    if (golden_q || res_ready_i) begin
                        if (!golden_q) begin
                            res_valid_o <= 1'b0;
                            if (res_det_o && (det_cnt_o != '1))
                                det_cnt_o <= det_cnt_o + FID_W'(1);
                        end
                        golden_q <= 1'b0;
                        if (fid_next_c < fid_end_q) begin
                            fault_id_o <= fid_next_c;
                            stim_o     <= '0;
                            state      <= S_INIT;
                        end else begin
                            fault_id_o <= NO_FAULT;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fault_campaign_ctrl.md
# fault_campaign_ctrl

Synthesizable fault-injection campaign sequencer for gate-netlist sensitivity runs. It replaces the per-fault stimulus loop in the simulation benches with hardware. It drives the fault-select ID into the fault-mux-instrumented netlist and generates a grouped, rate-prioritised input stimulus. It compresses each run's outputs into a MISR signature, compares each fault run against a golden (fault-free) run, and streams one result record per fault over a valid/ready interface.

## Interface
Parameters:
- IN_W, 24: DUT input width. Must be divisible by 3.
- OUT_W, 25: DUT output width and signature width.
- FID_W, 16: fault ID width. The all-ones ID is reserved as NO_FAULT.
- STEPS, 128: stimulus steps per run. Must be ≥1.
- PER_HI, 2: update period of group 0 (bits [IN_W/3-1:0]). Must be a power of 2.
- PER_MID, 32: update period of group 1 (middle third).
- PER_LO, 64: update period of group 2 (top third).
- SETTLE, 1: cycles the stimulus is held before `dut_out_i` is sampled.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous, active-low reset.
- start_i, in, 1: launches a campaign. Ignored unless the block is in IDLE or DONE.
- abort_i, in, 1: returns the block to IDLE on the next edge. Takes priority over everything except reset.
- fid_start_i, in, FID_W: first fault ID. Sampled when start is accepted.
- fid_end_i, in, FID_W: exclusive last fault ID. Sampled when start is accepted.
- fault_id_o, out, FID_W: fault select to the netlist mux.
- stim_o, out, IN_W: stimulus to the DUT.
- dut_out_i, in, OUT_W: DUT response.
- res_valid_o, out, 1: result record valid.
- res_ready_i, in, 1: result record accepted.
- res_fid_o, out, FID_W: fault ID of the record.
- res_det_o, out, 1: set when the fault signature differs from the golden signature.
- res_sig_o, out, OUT_W: fault-run signature.
- golden_sig_o, out, OUT_W: golden signature.
- det_cnt_o, out, FID_W: number of detected faults in the current campaign.
- busy_o, out, 1: set in INIT, RUN and EMIT.
- done_o, out, 1: set in DONE.

## Operation
- States: IDLE, INIT, RUN, EMIT, DONE.
- **IDLE/DONE + start_i:**
  - Latch the fault range.
  - Set `fault_id_o` to NO_FAULT (golden run).
  - Clear `det_cnt_o`.
  - Go to INIT.
- **INIT (1 cycle):**
  - `stim_o` = 0.
  - Signature cleared to 0.
  - Step counter cleared to 0.
  - Go to RUN.
- **RUN, step s:**
  - Stimulus update on the first cycle of step s. For each group g with period P_g where s mod P_g == 0, the group is loaded with gray(s) = s ^ (s>>1), truncated or zero-extended to IN_W/3. Other groups hold their value.
  - Sample on the last cycle of step s: sig ← rotl1(sig) ^ `dut_out_i`.
  - Step length is SETTLE+1 cycles.
  - After step STEPS-1, go to EMIT.
- **EMIT for the golden run:**
  - `golden_sig_o` ← sig.
  - No record is emitted.
  - Next fault ID is fid_start.
- **EMIT for a fault run:**
  - Assert `res_valid_o` with fid, det = (sig ≠ golden) and sig.
  - Record fields stay stable until `res_ready_i`.
  - On handshake, `det_cnt_o` increments if det is set.
- **After EMIT:** if the next fault ID < fid_end, set `fault_id_o` to it and go to INIT. Otherwise go to DONE.
- **Empty range:** if fid_start ≥ fid_end, the block runs golden only, then goes to DONE with no records.
- **DONE:** holds all outputs. `fault_id_o` = NO_FAULT.
- **Arithmetic:**
  - Step counter is ceil(log2(STEPS+1)) bits.
  - Fault ID increments modulo 2^FID_W. The campaign never reaches NO_FAULT because fid_end ≤ all-ones.
  - `det_cnt_o` saturates at all-ones.

## Timing
- **Reset values:**
  - `fault_id_o` = NO_FAULT.
  - `stim_o`, `res_*`, `golden_sig_o`, `det_cnt_o` = 0.
  - `busy_o` = 0, `done_o` = 0.
  - State = IDLE.
- **Run length:** a run occupies 1 + STEPS·(SETTLE+1) cycles, plus EMIT.
- **EMIT:** lasts 1 cycle for golden, and ≥1 cycle for a fault run (until handshake).
- **Start latency:** start accepted at edge N → INIT at N+1 → first stimulus at N+2.
- **`res_valid_o`:**
  - Rises on the EMIT entry edge.
  - Falls on the edge after the handshake.
  - Valid and ready in the same cycle as EMIT entry counts as a 1-cycle EMIT.
- **`fault_id_o`:** changes only on the EMIT→INIT edge. It is stable for the whole run.
- **abort_i, or rst_n low mid-run:**
  - Drops valid.
  - Restores reset values on the next edge.
  - A partial campaign's `det_cnt_o` is lost.
- **start_i while busy:** ignored. Ranges are not re-sampled.

## Test plan
- **Empty range:** STEPS=4, SETTLE=1, start with range 5..5 → `done_o` 10 cycles after acceptance, zero records, `det_cnt_o` = 0.
- **Stimulus schedule:** IN_W=6, PER_HI=1, PER_MID=2, PER_LO=4, STEPS=4 → group 0 sequence 0,1,3,2; group 1 sequence 0,0,3,3; group 2 sequence 0,0,0,0.
- **Detection:** DUT model out = zext(stim) ^ (fid==3 ? 1 : 0), range 2..5 → records fid 2,3,4 with det 0,1,0, `det_cnt_o` = 1, and sig of fid 3 ≠ `golden_sig_o`.
- **Backpressure:** hold `res_ready_i` low 7 cycles on the fid 3 record → fields stable, `fault_id_o` stays 3, next INIT only after the handshake.
- **Abort:** abort mid-RUN of fid 4 → next cycle IDLE, all outputs at reset values; a new start reruns golden.
- **Busy start:** start pulse while busy with a different range → ignored, original range completes.
